// File: rtl/bp_pkg.sv
// bp_pkg: shared types, constants and helpers for the branch predictor.
//
// Contents:
//   CTR_WEAK_TAKEN / CTR_WEAK_NT : 2-bit counter presets (MSB = prediction)
//   ctr_weak_taken / ctr_weak_nt : the same presets for any counter width
//   btb_entry_t                  : BTB entry {valid, tag, target}; the tag and
//                                  target fields are sized for the widest
//                                  configuration and zero-extended by users
//   ctr_op_e                     : counter-table write operation
//   bp_idx / bp_tag              : PC -> table index / tag extraction
//   bp_sat_inc / bp_sat_dec      : saturating counter arithmetic
package bp_pkg;

  localparam int BP_MAX_PC_W  = 64;
  localparam int BP_MAX_TAG_W = 32;

  localparam logic [1:0] CTR_WEAK_TAKEN = 2'b10;
  localparam logic [1:0] CTR_WEAK_NT    = 2'b01;

  typedef struct packed {
    logic                    valid;
    logic [BP_MAX_TAG_W-1:0] tag;
    logic [BP_MAX_PC_W-1:0]  target;
  } btb_entry_t;

  typedef enum logic [1:0] {
    CTR_OP_INC   = 2'd0,
    CTR_OP_DEC   = 2'd1,
    CTR_OP_ALLOC = 2'd2
  } ctr_op_e;

  // Weakly taken: MSB set, all other bits clear.
  function automatic logic [31:0] ctr_weak_taken(input int w);
    return 32'(1) << (w - 1);
  endfunction

  // Weakly not-taken: all bits below the MSB set (all-zero for a 1-bit counter).
  function automatic logic [31:0] ctr_weak_nt(input int w);
    return (32'(1) << (w - 1)) - 32'(1);
  endfunction

  // Word-aligned index: pc[idx_w+1:2].
  function automatic logic [31:0] bp_idx(input logic [BP_MAX_PC_W-1:0] pc, input int idx_w);
    logic [BP_MAX_PC_W-1:0] mask;
    mask = (BP_MAX_PC_W'(1) << idx_w) - BP_MAX_PC_W'(1);
    return 32'((pc >> 2) & mask);
  endfunction

  // Tag: the tag_w bits directly above the index; zero when untagged.
  function automatic logic [BP_MAX_TAG_W-1:0] bp_tag(input logic [BP_MAX_PC_W-1:0] pc,
                                                     input int idx_w, input int tag_w);
    logic [BP_MAX_PC_W-1:0] mask;
    if (tag_w == 0) return '0;
    mask = (BP_MAX_PC_W'(1) << tag_w) - BP_MAX_PC_W'(1);
    return BP_MAX_TAG_W'((pc >> (idx_w + 2)) & mask);
  endfunction

  function automatic logic [31:0] bp_sat_inc(input logic [31:0] c, input int w);
    logic [32:0] max_val;
    max_val = (33'(1) << w) - 33'(1);
    return (33'(c) >= max_val) ? 32'(max_val) : c + 32'(1);
  endfunction

  function automatic logic [31:0] bp_sat_dec(input logic [31:0] c);
    return (c == 32'(0)) ? c : c - 32'(1);
  endfunction

endpackage

// File: rtl/bp_sat_counter_table.sv
// bp_sat_counter_table: ENTRIES x CTR_W table of saturating counters.
//
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   rd_idx     : read index (combinational read of pre-edge state)
//   rd_ctr     : counter value at rd_idx
//   wr_en      : apply wr_op to the counter at wr_idx on the next edge
//   wr_idx     : write index
//   wr_op      : increment / decrement (both saturating) or allocate (weak taken)
//
// Reset puts every counter at weakly not-taken.
module bp_sat_counter_table
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2,
  localparam int IDX_W  = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CTR_W-1:0] rd_ctr,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  ctr_op_e          wr_op
);

  logic [CTR_W-1:0] ctr_q [ENTRIES];
  logic [CTR_W-1:0] ctr_d [ENTRIES];

  assign rd_ctr = ctr_q[rd_idx];

  always_comb begin
    ctr_d = ctr_q;
    if (wr_en) begin
      case (wr_op)
        CTR_OP_INC:   ctr_d[wr_idx] = CTR_W'(bp_sat_inc(32'(ctr_q[wr_idx]), CTR_W));
        CTR_OP_DEC:   ctr_d[wr_idx] = CTR_W'(bp_sat_dec(32'(ctr_q[wr_idx])));
        CTR_OP_ALLOC: ctr_d[wr_idx] = CTR_W'(ctr_weak_taken(CTR_W));
        default:      ctr_d[wr_idx] = ctr_q[wr_idx];
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_W'(ctr_weak_nt(CTR_W));
      end
    end else begin
      ctr_q <= ctr_d;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with saturating-counter direction
// prediction for the five-stage MIPS core.
//
// Fetch : lk_pc is looked up combinationally -> lk_hit / lk_taken / lk_target.
//         The prediction is carried into decode in the s2 register
//         (hold = stall_s1_s2 freezes it, clear = flush zeroes it; clear wins).
// Decode: upd_* describe the resolved branch. mispredict / redirect_pc drive
//         the PC mux; on the clock edge the BTB, counters and statistics update.
//
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   lk_pc -> lk_hit, lk_taken, lk_target   fetch lookup
//   hold, clear -> s2_taken, s2_target     decode-stage prediction register
//   upd_valid, upd_pc, upd_taken, upd_target  resolved branch
//   mispredict, redirect_pc            recovery outputs (combinational)
//   stat_branches, stat_mispredicts    saturating statistics
//
// Optional build macro BP_GSHARE_EN: counters are indexed by pc index XOR a
// global history register; the BTB stays pc-indexed.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int PC_W    = 32,
  parameter int TAG_W   = 8,
  parameter int CTR_W   = 2,
  parameter int STAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [PC_W-1:0]   lk_pc,
  output logic              lk_hit,
  output logic              lk_taken,
  output logic [PC_W-1:0]   lk_target,
  input  logic              hold,
  input  logic              clear,
  output logic              s2_taken,
  output logic [PC_W-1:0]   s2_target,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic              upd_taken,
  input  logic [PC_W-1:0]   upd_target,
  output logic              mispredict,
  output logic [PC_W-1:0]   redirect_pc,
  output logic [STAT_W-1:0] stat_branches,
  output logic [STAT_W-1:0] stat_mispredicts
);

  localparam int IDX_W = $clog2(ENTRIES);

  // BTB storage: valid bits carry the reset, tag/target data does not.
  logic [ENTRIES-1:0] valid_q;
  logic [ENTRIES-1:0] valid_d;
  btb_entry_t         btb_q [ENTRIES];

  logic [IDX_W-1:0]        lk_idx;
  logic [BP_MAX_TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0]        upd_idx;
  logic [BP_MAX_TAG_W-1:0] upd_tag;
  logic                    upd_hit;

  logic [IDX_W-1:0] ctr_rd_idx;
  logic [CTR_W-1:0] ctr_rd;
  logic             ctr_we;
  logic [IDX_W-1:0] ctr_wr_idx;
  ctr_op_e          ctr_op;

  logic              s2_taken_q,  s2_taken_d;
  logic [PC_W-1:0]   s2_target_q, s2_target_d;
  logic [STAT_W-1:0] stat_branches_q,    stat_branches_d;
  logic [STAT_W-1:0] stat_mispredicts_q, stat_mispredicts_d;

`ifdef BP_GSHARE_EN
  logic [IDX_W-1:0] ghr_q, ghr_d;
  logic [IDX_W-1:0] s2_idx_q, s2_idx_d;
`endif

  // ---------------------------------------------------------------- lookup
  always_comb begin
    lk_idx = IDX_W'(bp_idx(BP_MAX_PC_W'(lk_pc), IDX_W));
    lk_tag = bp_tag(BP_MAX_PC_W'(lk_pc), IDX_W, TAG_W);
`ifdef BP_GSHARE_EN
    ctr_rd_idx = lk_idx ^ ghr_q;
`else
    ctr_rd_idx = lk_idx;
`endif
    // The stored valid field is always written as 1; valid_q is what resets.
    lk_hit    = valid_q[lk_idx] && btb_q[lk_idx].valid && (btb_q[lk_idx].tag == lk_tag);
    // ">= weak taken" is the same test as "counter MSB set".
    lk_taken  = lk_hit && (ctr_rd >= CTR_W'(ctr_weak_taken(CTR_W)));
    // Zeroed on a miss so untouched (unreset) target data never leaks into s2.
    lk_target = lk_hit ? PC_W'(btb_q[lk_idx].target) : '0;
  end

  bp_sat_counter_table #(
    .ENTRIES (ENTRIES),
    .CTR_W   (CTR_W)
  ) u_ctr_table (
    .clk    (clk),
    .rst_n  (rst_n),
    .rd_idx (ctr_rd_idx),
    .rd_ctr (ctr_rd),
    .wr_en  (ctr_we),
    .wr_idx (ctr_wr_idx),
    .wr_op  (ctr_op)
  );

  // ------------------------------------------------------ s2 prediction reg
  always_comb begin
    s2_taken_d  = s2_taken_q;
    s2_target_d = s2_target_q;
`ifdef BP_GSHARE_EN
    s2_idx_d    = s2_idx_q;
`endif
    if (clear) begin
      s2_taken_d  = 1'b0;
      s2_target_d = '0;
`ifdef BP_GSHARE_EN
      s2_idx_d    = '0;
`endif
    end else if (!hold) begin
      s2_taken_d  = lk_taken;
      s2_target_d = lk_target;
`ifdef BP_GSHARE_EN
      s2_idx_d    = ctr_rd_idx;
`endif
    end
  end

  assign s2_taken  = s2_taken_q;
  assign s2_target = s2_target_q;

  // ------------------------------------------------------ resolve / update
  always_comb begin
    upd_idx = IDX_W'(bp_idx(BP_MAX_PC_W'(upd_pc), IDX_W));
    upd_tag = bp_tag(BP_MAX_PC_W'(upd_pc), IDX_W, TAG_W);
    upd_hit = valid_q[upd_idx] && btb_q[upd_idx].valid && (btb_q[upd_idx].tag == upd_tag);

    mispredict  = upd_valid &&
                  ((upd_taken != s2_taken_q) || (upd_taken && (upd_target != s2_target_q)));
    redirect_pc = upd_taken ? upd_target : upd_pc + PC_W'(4);

    // Miss + not-taken leaves the counter alone; miss + taken allocates.
    ctr_we = upd_valid && (upd_hit || upd_taken);
    ctr_op = upd_hit ? (upd_taken ? CTR_OP_INC : CTR_OP_DEC) : CTR_OP_ALLOC;
`ifdef BP_GSHARE_EN
    ctr_wr_idx = s2_idx_q;
`else
    ctr_wr_idx = upd_idx;
`endif

    // A taken branch either refreshes the target of its hit entry or
    // allocates over whatever occupied the slot; both are the same write.
    valid_d = valid_q;
    if (upd_valid && upd_taken) begin
      valid_d[upd_idx] = 1'b1;
    end

    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (upd_valid) begin
      stat_branches_d = STAT_W'(bp_sat_inc(32'(stat_branches_q), STAT_W));
    end
    if (mispredict) begin
      stat_mispredicts_d = STAT_W'(bp_sat_inc(32'(stat_mispredicts_q), STAT_W));
    end
  end

`ifdef BP_GSHARE_EN
  // Oldest outcome falls off the top; newest enters at bit 0.
  assign ghr_d = upd_valid ? IDX_W'({ghr_q, upd_taken}) : ghr_q;
`endif

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;

  // ------------------------------------------------------------ registers
  always_ff @(posedge clk) begin
    if (upd_valid && upd_taken) begin
      btb_q[upd_idx] <= '{valid:  1'b1,
                          tag:    upd_tag,
                          target: BP_MAX_PC_W'(upd_target)};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q            <= '0;
      s2_taken_q         <= 1'b0;
      s2_target_q        <= '0;
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
`ifdef BP_GSHARE_EN
      ghr_q              <= '0;
      s2_idx_q           <= '0;
`endif
    end else begin
      valid_q            <= valid_d;
      s2_taken_q         <= s2_taken_d;
      s2_target_q        <= s2_target_d;
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
`ifdef BP_GSHARE_EN
      ghr_q              <= ghr_d;
      s2_idx_q           <= s2_idx_d;
`endif
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Testbench for branch_predictor (default build, STAT_W = 4 so that
// statistics saturation is reachable in a short run).
module tb_branch_predictor;

  localparam int PC_W   = 32;
  localparam int STAT_W = 4;
  localparam int SMAX   = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [PC_W-1:0]   lk_pc;
  logic              lk_hit, lk_taken;
  logic [PC_W-1:0]   lk_target;
  logic              hold, clear;
  logic              s2_taken;
  logic [PC_W-1:0]   s2_target;
  logic              upd_valid;
  logic [PC_W-1:0]   upd_pc;
  logic              upd_taken;
  logic [PC_W-1:0]   upd_target;
  logic              mispredict;
  logic [PC_W-1:0]   redirect_pc;
  logic [STAT_W-1:0] stat_branches, stat_mispredicts;

  int checks = 0;
  int errors = 0;

  branch_predictor #(
    .ENTRIES (16),
    .PC_W    (PC_W),
    .TAG_W   (8),
    .CTR_W   (2),
    .STAT_W  (STAT_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .lk_pc            (lk_pc),
    .lk_hit           (lk_hit),
    .lk_taken         (lk_taken),
    .lk_target        (lk_target),
    .hold             (hold),
    .clear            (clear),
    .s2_taken         (s2_taken),
    .s2_target        (s2_target),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ------------------------------------------------ directed vector table
  typedef struct {
    logic [31:0] lk;
    logic        hold, clear, uv;
    logic [31:0] upc;
    logic        ut;
    logic [31:0] utgt;
    logic        e_hit, e_taken;
    logic [31:0] e_tgt;
    logic        e_s2t;
    logic [31:0] e_s2tgt;
    logic        e_misp;
    logic [31:0] e_redir;
    int          e_sb, e_sm;
  } vec_t;

  function automatic vec_t mk(logic [31:0] lk, logic h, logic c, logic uv, logic [31:0] upc,
                              logic ut, logic [31:0] utgt, logic eh, logic et, logic [31:0] etg,
                              logic es2t, logic [31:0] es2tg, logic em, logic [31:0] er,
                              int sb, int sm);
    vec_t v;
    v.lk = lk; v.hold = h; v.clear = c; v.uv = uv; v.upc = upc; v.ut = ut; v.utgt = utgt;
    v.e_hit = eh; v.e_taken = et; v.e_tgt = etg; v.e_s2t = es2t; v.e_s2tgt = es2tg;
    v.e_misp = em; v.e_redir = er; v.e_sb = sb; v.e_sm = sm;
    return v;
  endfunction

  // ------------------------------------------------- behavioural reference
  // Entries kept as plain integers: counter value 0..3, prediction = ctr >= 2.
  bit          m_valid [16];
  int unsigned m_tag   [16];
  int unsigned m_tgt   [16];
  int          m_ctr   [16];
  bit          m_s2t;
  int unsigned m_s2tgt;
  int          m_sb, m_sm;

  function automatic int unsigned f_idx(int unsigned pc);
    return (pc / 4) % 16;
  endfunction
  function automatic int unsigned f_tag(int unsigned pc);
    return (pc / 64) % 256;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_ctr[i] = 1;
    end
    m_s2t = 0; m_s2tgt = 0; m_sb = 0; m_sm = 0;
  endfunction

  function automatic void model_lookup(input int unsigned pc, output bit h, output bit t,
                                       output int unsigned tg);
    int unsigned i;
    i  = f_idx(pc);
    h  = m_valid[i] && (m_tag[i] == f_tag(pc));
    t  = h && (m_ctr[i] >= 2);
    tg = h ? m_tgt[i] : 0;
  endfunction

  function automatic bit model_misp();
    return upd_valid && ((upd_taken != m_s2t) || (upd_taken && (upd_target != m_s2tgt)));
  endfunction

  // Advance the model across one clock edge using the current inputs.
  function automatic void model_edge();
    bit h, t, uh, mp;
    int unsigned tg, ui;
    model_lookup(lk_pc, h, t, tg);
    mp = model_misp();
    ui = f_idx(upd_pc);
    uh = m_valid[ui] && (m_tag[ui] == f_tag(upd_pc));
    if (clear) begin
      m_s2t = 0; m_s2tgt = 0;
    end else if (!hold) begin
      m_s2t = t; m_s2tgt = tg;
    end
    if (upd_valid) begin
      m_sb = (m_sb + 1 > SMAX) ? SMAX : m_sb + 1;
      if (mp) m_sm = (m_sm + 1 > SMAX) ? SMAX : m_sm + 1;
      if (uh) begin
        if (upd_taken) begin
          m_ctr[ui] = (m_ctr[ui] + 1 > 3) ? 3 : m_ctr[ui] + 1;
          m_tgt[ui] = upd_target;
        end else begin
          m_ctr[ui] = (m_ctr[ui] - 1 < 0) ? 0 : m_ctr[ui] - 1;
        end
      end else if (upd_taken) begin
        m_valid[ui] = 1; m_tag[ui] = f_tag(upd_pc); m_tgt[ui] = upd_target; m_ctr[ui] = 2;
      end
    end
  endfunction

  function automatic logic [31:0] rand_pc();
    return ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2);
  endfunction

  vec_t vecs [15];

  initial begin
    bit e_h, e_t;
    int unsigned e_tg;

    // Table rows follow one branch at 0x40 and its alias at 0x440 (same index).
    vecs[0]  = mk('h40,  0,0,0,'h0,  0,'h0,   0,0,'h0,   0,'h0,   0,'h0,   0,0);
    vecs[1]  = mk('h40,  0,0,1,'h40, 1,'h80,  0,0,'h0,   0,'h0,   1,'h80,  0,0);
    vecs[2]  = mk('h40,  0,0,0,'h0,  0,'h0,   1,1,'h80,  0,'h0,   0,'h0,   1,1);
    vecs[3]  = mk('h40,  0,0,1,'h40, 0,'h80,  1,1,'h80,  1,'h80,  1,'h44,  1,1);
    vecs[4]  = mk('h40,  0,0,1,'h40, 0,'h80,  1,0,'h80,  1,'h80,  1,'h44,  2,2);
    vecs[5]  = mk('h440, 0,0,0,'h0,  0,'h0,   0,0,'h0,   0,'h80,  0,'h0,   3,3);
    vecs[6]  = mk('h440, 0,0,1,'h440,1,'h100, 0,0,'h0,   0,'h0,   1,'h100, 3,3);
    vecs[7]  = mk('h440, 0,0,0,'h0,  0,'h0,   1,1,'h100, 0,'h0,   0,'h0,   4,4);
    vecs[8]  = mk('h40,  1,0,0,'h0,  0,'h0,   0,0,'h0,   1,'h100, 0,'h0,   4,4);
    vecs[9]  = mk('h48,  1,0,0,'h0,  0,'h0,   0,0,'h0,   1,'h100, 0,'h0,   4,4);
    vecs[10] = mk('h50,  1,0,0,'h0,  0,'h0,   0,0,'h0,   1,'h100, 0,'h0,   4,4);
    vecs[11] = mk('h440, 0,0,1,'h440,1,'h100, 1,1,'h100, 1,'h100, 0,'h100, 4,4);
    vecs[12] = mk('h440, 1,1,0,'h0,  0,'h0,   1,1,'h100, 1,'h100, 0,'h0,   5,4);
    vecs[13] = mk('h440, 1,0,1,'h440,1,'h200, 1,1,'h100, 0,'h0,   1,'h200, 5,4);
    vecs[14] = mk('h440, 0,0,0,'h0,  0,'h0,   1,1,'h200, 0,'h0,   0,'h0,   6,5);

    // ---------------------------------------------------------- reset
    rst_n = 1'b0; lk_pc = 'h40; hold = 0; clear = 0;
    upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
    #3;
    chk("reset_lk_hit",   lk_hit, 0);
    chk("reset_lk_taken", lk_taken, 0);
    chk("reset_s2_taken", s2_taken, 0);
    chk("reset_s2_target", s2_target, 0);
    chk("reset_mispredict", mispredict, 0);
    chk("reset_stat_br", stat_branches, 0);
    chk("reset_stat_mp", stat_mispredicts, 0);
    tick(); tick();
    rst_n = 1'b1;

    // ---------------------------------------------------- table vectors
    for (int v = 0; v < 15; v++) begin
      lk_pc = vecs[v].lk; hold = vecs[v].hold; clear = vecs[v].clear;
      upd_valid = vecs[v].uv; upd_pc = vecs[v].upc;
      upd_taken = vecs[v].ut; upd_target = vecs[v].utgt;
      #2;
      $display("vec %0d lk_pc=%h hold=%0b clear=%0b upd=%0b pc=%h taken=%0b tgt=%h",
               v, lk_pc, hold, clear, upd_valid, upd_pc, upd_taken, upd_target);
      chk($sformatf("v%0d_lk_hit", v),    lk_hit,    vecs[v].e_hit);
      chk($sformatf("v%0d_lk_taken", v),  lk_taken,  vecs[v].e_taken);
      chk($sformatf("v%0d_lk_target", v), lk_target, vecs[v].e_tgt);
      chk($sformatf("v%0d_s2_taken", v),  s2_taken,  vecs[v].e_s2t);
      chk($sformatf("v%0d_s2_target", v), s2_target, vecs[v].e_s2tgt);
      chk($sformatf("v%0d_mispredict", v), mispredict, vecs[v].e_misp);
      if (vecs[v].uv) chk($sformatf("v%0d_redirect", v), redirect_pc, vecs[v].e_redir);
      chk($sformatf("v%0d_stat_br", v), stat_branches, 64'(vecs[v].e_sb));
      chk($sformatf("v%0d_stat_mp", v), stat_mispredicts, 64'(vecs[v].e_sm));
      tick();
    end

    // ------------------------------- statistics saturation (20 mispredicts)
    // clear keeps s2 at "not taken", so every taken branch mispredicts.
    for (int i = 0; i < 20; i++) begin
      lk_pc = 'h40; hold = 0; clear = 1;
      upd_valid = 1; upd_pc = 'h800 + 4 * i; upd_taken = 1; upd_target = 'h900;
      #2;
      chk($sformatf("sat%0d_mispredict", i), mispredict, 1);
      tick();
    end
    upd_valid = 0; clear = 0; lk_pc = 'h840;
    #2;
    $display("saturation: stat_branches=%0d stat_mispredicts=%0d", stat_branches, stat_mispredicts);
    chk("sat_stat_br", stat_branches, SMAX);
    chk("sat_stat_mp", stat_mispredicts, SMAX);
    chk("pre_rst_lk_hit", lk_hit, 1);
    chk("pre_rst_lk_target", lk_target, 'h900);
    tick();
    chk("pre_rst_s2_taken", s2_taken, 1);

    // -------------------------------- asynchronous reset, mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk("arst_lk_hit",    lk_hit, 0);
    chk("arst_lk_taken",  lk_taken, 0);
    chk("arst_s2_taken",  s2_taken, 0);
    chk("arst_s2_target", s2_target, 0);
    chk("arst_stat_br",   stat_branches, 0);
    chk("arst_stat_mp",   stat_mispredicts, 0);
    tick();
    rst_n = 1'b1;
    #2;
    chk("post_rst_lk_hit", lk_hit, 0);
    tick();

    // -------------------------------------- randomized vs reference model
    model_reset();
    for (int n = 0; n < 400; n++) begin
      lk_pc      = rand_pc();
      hold       = ($urandom_range(0, 99) < 15);
      clear      = ($urandom_range(0, 99) < 8);
      upd_valid  = ($urandom_range(0, 1) == 1);
      upd_pc     = rand_pc();
      upd_taken  = ($urandom_range(0, 1) == 1);
      upd_target = 'h1000 + ($urandom_range(0, 3) << 4);
      #2;
      model_lookup(lk_pc, e_h, e_t, e_tg);
      chk($sformatf("r%0d_lk_hit", n),    lk_hit,    e_h);
      chk($sformatf("r%0d_lk_taken", n),  lk_taken,  e_t);
      chk($sformatf("r%0d_lk_target", n), lk_target, e_tg);
      chk($sformatf("r%0d_s2_taken", n),  s2_taken,  m_s2t);
      chk($sformatf("r%0d_s2_target", n), s2_target, m_s2tgt);
      chk($sformatf("r%0d_mispredict", n), mispredict, model_misp());
      if (upd_valid)
        chk($sformatf("r%0d_redirect", n), redirect_pc, upd_taken ? upd_target : upd_pc + 4);
      chk($sformatf("r%0d_stat_br", n), stat_branches, 64'(m_sb));
      chk($sformatf("r%0d_stat_mp", n), stat_mispredicts, 64'(m_sm));
      model_edge();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised dynamic branch predictor for the five-stage MIPS core.
- Fetch stage: combinational lookup of the PC in a direct-mapped BTB with per-entry saturating counters. The lookup result is carried into decode alongside inst_s2 through a hold/clear pipeline register.
- Decode stage: the branch resolves (data1 == data2 comparator). The block updates its tables and raises mispredict/redirect_pc for the PC mux.
- Generalises the 2-bit {H,P} prediction register to N entries, configurable counter width, tags and statistics.

Parameters:
- ENTRIES, 16, BTB/counter table depth; power of two, >= 2.
- PC_W, 32, PC and target width.
- TAG_W, 8, tag bits stored per entry; 0 = untagged.
- CTR_W, 2, saturating counter width, >= 1.
- STAT_W, 16, width of statistics counters.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- lk_pc  in  PC_W  fetch-stage PC (pc).
- lk_hit  out  1  BTB entry valid and tag matches.
- lk_taken  out  1  predicted taken (lk_hit && counter MSB).
- lk_target  out  PC_W  predicted target (meaningful only when lk_hit).
- hold  in  1  stall_s1_s2; freezes s2 prediction register.
- clear  in  1  flush of s1->s2; zeroes s2 prediction register.
- s2_taken  out  1  registered lk_taken for the instruction in decode.
- s2_target  out  PC_W  registered lk_target.
- upd_valid  in  1  decode holds a resolved conditional branch (beq/bne), single cycle.
- upd_pc  in  PC_W  PC of that branch.
- upd_taken  in  1  actual outcome.
- upd_target  in  PC_W  actual branch target (baddr_s2).
- mispredict  out  1  combinational; flush s1 and redirect.
- redirect_pc  out  PC_W  upd_taken ? upd_target : upd_pc+4.
- stat_branches  out  STAT_W  resolved branch count.
- stat_mispredicts  out  STAT_W  mispredict count.

Behaviour:
- IDX_W = log2(ENTRIES).
- idx = pc[IDX_W+1:2].
- tag = pc[IDX_W+1+TAG_W : IDX_W+2].
- Lookup is purely combinational and reads pre-edge state. A same-cycle update to the same index is not visible until the next cycle (read-old).
- s2 register, on posedge:
  - clear has priority over hold: s2_taken <= 0, s2_target <= 0, s2_idx <= 0.
  - else if hold: no change.
  - else capture lk_taken, lk_target, lookup idx.
- mispredict = upd_valid && (upd_taken != s2_taken || (upd_taken && upd_target != s2_target)). It is 0 when upd_valid is low.
- Update on posedge when upd_valid, indexed by upd_pc:
  - Hit: counter +1 if taken, -1 if not, saturating at 0 and 2^CTR_W-1. Target rewritten if taken.
  - Miss and taken: allocate/overwrite the entry: valid = 1, tag, target, counter = weakly taken (MSB=1, others 0, i.e. 2'b10).
  - Miss and not taken: no change.
- Statistics, each saturating at all-ones (no wrap):
  - stat_branches +1 per upd_valid.
  - stat_mispredicts +1 per mispredict.
- upd_valid together with hold: update still performed. The decode stage asserts upd_valid only once per branch.
- Reset (async, rst_n low):
  - All valid bits 0; counters = weakly not-taken (2'b01; all-zero when CTR_W = 1).
  - s2 register 0; statistics 0.
  - Outputs: lk_hit = 0, lk_taken = 0, s2_* = 0, mispredict = 0.
  - Targets and tags need not reset.
- Reset mid-operation discards all history. The first post-reset lookup always misses.

Optional Feature:
- Macro BP_GSHARE_EN.
- Defined:
  - An IDX_W-bit global history register (reset 0) shifts in upd_taken on each upd_valid.
  - Counter index = pc idx XOR GHR at lookup time. That index is carried in s2_idx and used for the counter update.
  - BTB tag/target remain indexed by pc idx.
- Undefined: counters indexed by pc idx only; no GHR logic is generated.

Decomposition:
- Package bp_pkg holds:
  - Constants: CTR_WEAK_TAKEN, CTR_WEAK_NT.
  - Functions: idx and tag extraction, saturating increment/decrement.
  - Typedef: btb_entry_t (valid, tag, target).
- One sub-module: bp_sat_counter_table (ENTRIES x CTR_W array, async reset, one read port, one write port with inc/dec). BTB storage stays in the top level.

Test Plan:
- Reset then lk_pc=0x40: lk_hit=0, lk_taken=0. stats 0.
- Cold branch at 0x40 taken to 0x80, upd_valid with s2_taken=0: mispredict=1, redirect_pc=0x80. Next lookup 0x40: hit=1, taken=1, target=0x80.
- Same branch resolved not-taken twice: counter 10->01->00. lk_taken=0 after first update. redirect_pc=0x44 on the first.
- Aliasing with ENTRIES=16, TAG_W=8: PC 0x40 and 0x440 share an index. After allocating 0x40, lookup 0x440 gives lk_hit=0. A taken 0x440 update replaces the entry.
- hold=1 for 3 cycles while lk_pc changes: s2_* frozen. clear with hold together: s2_* = 0.
- STAT_W=4: 20 mispredicting branches give stat_branches=stat_mispredicts=15 (saturated). rst_n pulsed low mid-cycle: all outputs 0 immediately, no clock needed.
